ctrl_unit_v2: RTL and testbench

CTRL_UNIT_V2 -- requirements
Module: ctrl_unit_v2

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/mem_wait_cnt.sv | 38 +++
 rtl/ctrl_unit_v2.sv | 142 ++++++++++++++
 tb/tb_ctrl_unit_v2.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator-machine control unit: state codes,
// opcodes, accumulator-source selects and the packed control word.
package ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_INREL  = 4'd7,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_INPUT  = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  typedef struct packed {
    logic       ir_load;
    logic       pc_load;
    logic       jmp_mux;
    logic       mem_inst;
    logic       mem_wr;
    logic       a_load;
    logic       sub;
    logic       halt;
    logic [1:0] asel;
  } ctrl_t;

  function automatic state_t op_to_state(input logic [2:0] op);
    state_t s;
    case (op)
      OP_LOAD:  s = S_LOAD;
      OP_STORE: s = S_STORE;
      OP_ADD:   s = S_ADD;
      OP_SUB:   s = S_SUB;
      OP_INPUT: s = S_INPUT;
      OP_JZ:    s = S_JZ;
      OP_JPOS:  s = S_JPOS;
      default:  s = S_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory wait counter: counts cycles spent in an access state and flags the
// final one (count == MEM_LAT-1); saturates there, clear has priority.
module mem_wait_cnt
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_unit_v2.sv
// Multi-cycle control unit for a simple accumulator machine with MEM_LAT-cycle memory.
// Define CTRL_UNIT_SINGLE_STEP_EN to add a Step input that gates START, one instruction per Step rise.
module ctrl_unit_v2
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned STATE_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
`ifdef CTRL_UNIT_SINGLE_STEP_EN
  input  logic               Step,
`endif
  input  logic [2:0]         IR,
  input  logic               Aeq0,
  input  logic               Apos,
  input  logic               Enter,
  output logic               IRload,
  output logic               PCload,
  output logic               JMPmux,
  output logic               Meminst,
  output logic               MemWr,
  output logic               Aload,
  output logic               Sub,
  output logic               Halt,
  output logic [1:0]         Asel,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] nstate
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   wait_st;
  logic   cnt_done;
  logic   go;

`ifdef CTRL_UNIT_SINGLE_STEP_EN
  logic step_q, step_d;

  always_comb begin
    step_d = Step;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end

  assign go = Step && !step_q;
`else
  assign go = 1'b1;
`endif

  // Clearing whenever the counter is idle or finishing guarantees it is zero on every entry.
  assign wait_st = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);

  mem_wait_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_wait (
    .Clock (Clock),
    .Reset (Reset),
    .clear (!wait_st || cnt_done),
    .enable(wait_st),
    .done  (cnt_done)
  );

  always_comb begin
    state_d = S_START;
    ctrl    = '0;
    case (state_q)
      S_START:  state_d = go ? S_FETCH : S_START;
      S_FETCH: begin
        ctrl.mem_inst = 1'b1;
        ctrl.ir_load  = cnt_done;
        ctrl.pc_load  = cnt_done;
        state_d       = cnt_done ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = op_to_state(IR);
      S_LOAD: begin
        ctrl.asel   = ASEL_MEM;
        ctrl.a_load = cnt_done;
        state_d     = cnt_done ? S_START : S_LOAD;
      end
      S_STORE: begin
        ctrl.mem_wr = cnt_done;
        state_d     = cnt_done ? S_START : S_STORE;
      end
      S_ADD: begin
        ctrl.a_load = 1'b1;
        ctrl.asel   = ASEL_ALU;
      end
      S_SUB: begin
        ctrl.a_load = 1'b1;
        ctrl.sub    = 1'b1;
        ctrl.asel   = ASEL_ALU;
      end
      S_INPUT: begin
        ctrl.asel   = ASEL_IN;
        ctrl.a_load = Enter;
        state_d     = Enter ? S_INREL : S_INPUT;
      end
      S_INREL:  state_d = Enter ? S_INREL : S_START;
      S_JZ: begin
        ctrl.jmp_mux = 1'b1;
        ctrl.pc_load = Aeq0;
      end
      S_JPOS: begin
        ctrl.jmp_mux = 1'b1;
        ctrl.pc_load = Apos;
      end
      S_HALT: begin
        ctrl.halt = 1'b1;
        state_d   = S_HALT;
      end
      default:  state_d = S_START;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  assign IRload  = ctrl.ir_load;
  assign PCload  = ctrl.pc_load;
  assign JMPmux  = ctrl.jmp_mux;
  assign Meminst = ctrl.mem_inst;
  assign MemWr   = ctrl.mem_wr;
  assign Aload   = ctrl.a_load;
  assign Sub     = ctrl.sub;
  assign Halt    = ctrl.halt;
  assign Asel    = ctrl.asel;
  assign state   = STATE_W'(state_q);
  assign nstate  = STATE_W'(state_d);

endmodule

// File: tb/tb_ctrl_unit_v2.sv
// Directed scoreboard bench: two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus;
// expected per-cycle state/nstate/control words are queued and compared each cycle.
module tb_ctrl_unit_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ir = 3'b000;
  logic       aeq0 = 1'b0;
  logic       apos = 1'b0;
  logic       enter = 1'b0;
`ifdef CTRL_UNIT_SINGLE_STEP_EN
  logic       step = 1'b0;
  always @(negedge clk) step = ~step;
`endif

  always #5 clk = ~clk;

  // control word bit order: IRload PCload JMPmux Meminst MemWr Aload Sub Halt Asel[1:0]
  localparam logic [9:0] C_IRL = 10'b1000000000;
  localparam logic [9:0] C_PCL = 10'b0100000000;
  localparam logic [9:0] C_JMP = 10'b0010000000;
  localparam logic [9:0] C_MI  = 10'b0001000000;
  localparam logic [9:0] C_MW  = 10'b0000100000;
  localparam logic [9:0] C_AL  = 10'b0000010000;
  localparam logic [9:0] C_SUB = 10'b0000001000;
  localparam logic [9:0] C_HLT = 10'b0000000100;
  localparam logic [9:0] A_IN  = 10'b0000000001;
  localparam logic [9:0] A_MEM = 10'b0000000010;
  localparam logic [9:0] F_FIN = C_MI | C_IRL | C_PCL;

  wire [9:0] c1, c3;
  wire [3:0] st1, ns1, st3, ns3;

  ctrl_unit_v2 #(.MEM_LAT(1), .STATE_W(4)) dut1 (
    .Clock(clk), .Reset(rst),
`ifdef CTRL_UNIT_SINGLE_STEP_EN
    .Step(step),
`endif
    .IR(ir), .Aeq0(aeq0), .Apos(apos), .Enter(enter),
    .IRload(c1[9]), .PCload(c1[8]), .JMPmux(c1[7]), .Meminst(c1[6]), .MemWr(c1[5]),
    .Aload(c1[4]), .Sub(c1[3]), .Halt(c1[2]), .Asel(c1[1:0]),
    .state(st1), .nstate(ns1)
  );

  ctrl_unit_v2 #(.MEM_LAT(3), .STATE_W(4)) dut3 (
    .Clock(clk), .Reset(rst),
`ifdef CTRL_UNIT_SINGLE_STEP_EN
    .Step(step),
`endif
    .IR(ir), .Aeq0(aeq0), .Apos(apos), .Enter(enter),
    .IRload(c3[9]), .PCload(c3[8]), .JMPmux(c3[7]), .Meminst(c3[6]), .MemWr(c3[5]),
    .Aload(c3[4]), .Sub(c3[3]), .Halt(c3[2]), .Asel(c3[1:0]),
    .state(st3), .nstate(ns3)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ns;
    logic [9:0] c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   use3 = 1'b0;
  int   aload1_cnt = 0;
  int   memwr3_cnt = 0;

  // Pulse counters sampled mid-cycle, well clear of both edges.
  always @(negedge clk) begin
    #3;
    if (c1[4] === 1'b1) aload1_cnt++;
    if (c3[5] === 1'b1) memwr3_cnt++;
  end

  task automatic check_v(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] n, input logic [9:0] c);
    exp_t e;
    e.st = s;
    e.ns = n;
    e.c  = c;
    q.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [3:0] s, input logic [3:0] n,
                           input logic [9:0] c);
    check_v({tag, "_state"},  16'(use3 ? st3 : st1), 16'(s));
    check_v({tag, "_nstate"}, 16'(use3 ? ns3 : ns1), 16'(n));
    check_v({tag, "_ctrl"},   16'(use3 ? c3 : c1),   16'(c));
  endtask

  // Called at a falling edge: let inputs settle, compare, move to the next falling edge.
  task automatic pop_chk(input string tag);
    exp_t e;
    #1;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      check_now(tag, e.st, e.ns, e.c);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() > 0; i++) pop_chk(tag);
  endtask

  task automatic do_reset(input bit sel);
    use3 = sel;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_v("reset_state", 16'(sel ? st3 : st1), 16'h0);
    check_v("reset_ctrl",  16'(sel ? c3 : c1),   16'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_simple(input string tag, input logic [2:0] op, input logic [3:0] es,
                            input logic [9:0] ec);
    do_reset(1'b0);
    ir = op;
    push(4'h0, 4'h1, 10'h0);
    push(4'h1, 4'h2, F_FIN);
    push(4'h2, es, 10'h0);
    push(es, 4'h0, ec);
    push(4'h0, 4'h1, 10'h0);
    drain(tag);
  endtask

  int a0, m0;

  initial begin
    // single-cycle-memory instructions
    run_simple("add",    3'b010, 4'hA, C_AL);
    run_simple("sub",    3'b011, 4'hB, C_AL | C_SUB);
    run_simple("load1",  3'b000, 4'h8, C_AL | A_MEM);
    run_simple("store1", 3'b001, 4'h9, C_MW);
    aeq0 = 1'b0; apos = 1'b1;
    run_simple("jz0",    3'b101, 4'hD, C_JMP);
    aeq0 = 1'b1; apos = 1'b0;
    run_simple("jz1",    3'b101, 4'hD, C_JMP | C_PCL);
    aeq0 = 1'b1; apos = 1'b0;
    run_simple("jpos0",  3'b110, 4'hE, C_JMP);
    aeq0 = 1'b0; apos = 1'b1;
    run_simple("jpos1",  3'b110, 4'hE, C_JMP | C_PCL);
    apos = 1'b0;

    // INPUT: wait, Enter held 5 cycles, release
    do_reset(1'b0);
    ir = 3'b100;
    enter = 1'b0;
    push(4'h0, 4'h1, 10'h0);
    push(4'h1, 4'h2, F_FIN);
    push(4'h2, 4'hC, 10'h0);
    push(4'hC, 4'hC, A_IN);
    push(4'hC, 4'hC, A_IN);
    drain("in_wait");
    a0 = aload1_cnt;
    enter = 1'b1;
    push(4'hC, 4'h7, C_AL | A_IN);
    pop_chk("in_enter");
    for (int i = 0; i < 4; i++) begin
      push(4'h7, 4'h7, 10'h0);
      pop_chk("inrel_hold");
    end
    enter = 1'b0;
    push(4'h7, 4'h0, 10'h0);
    push(4'h0, 4'h1, 10'h0);
    drain("inrel_exit");
    check_v("in_aload_pulses", 16'(aload1_cnt - a0), 16'd1);

    // HALT holds for 50 cycles
    do_reset(1'b0);
    ir = 3'b111;
    push(4'h0, 4'h1, 10'h0);
    push(4'h1, 4'h2, F_FIN);
    push(4'h2, 4'hF, 10'h0);
    for (int i = 0; i < 50; i++) push(4'hF, 4'hF, C_HLT);
    drain("halt");

    // MEM_LAT=3 LOAD
    do_reset(1'b1);
    ir = 3'b000;
    push(4'h0, 4'h1, 10'h0);
    push(4'h1, 4'h1, C_MI);
    push(4'h1, 4'h1, C_MI);
    push(4'h1, 4'h2, F_FIN);
    push(4'h2, 4'h8, 10'h0);
    push(4'h8, 4'h8, A_MEM);
    push(4'h8, 4'h8, A_MEM);
    push(4'h8, 4'h0, C_AL | A_MEM);
    push(4'h0, 4'h1, 10'h0);
    drain("load3");

    // MEM_LAT=3 STORE aborted by reset in its 2nd cycle
    do_reset(1'b1);
    ir = 3'b001;
    m0 = memwr3_cnt;
    push(4'h0, 4'h1, 10'h0);
    push(4'h1, 4'h1, C_MI);
    push(4'h1, 4'h1, C_MI);
    push(4'h1, 4'h2, F_FIN);
    push(4'h2, 4'h9, 10'h0);
    push(4'h9, 4'h9, 10'h0);
    drain("store3");
    #2;
    rst = 1'b1;
    #1;
    check_v("abort_state", 16'(st3), 16'h0);
    check_v("abort_ctrl",  16'(c3),  16'h0);
    @(negedge clk);
    #1;
    check_v("abort_hold_state", 16'(st3), 16'h0);
    check_v("abort_hold_ctrl",  16'(c3),  16'h0);
    @(negedge clk);
    rst = 1'b0;
    ir = 3'b010;
    push(4'h0, 4'h1, 10'h0);
    push(4'h1, 4'h1, C_MI);
    push(4'h1, 4'h1, C_MI);
    push(4'h1, 4'h2, F_FIN);
    push(4'h2, 4'hA, 10'h0);
    push(4'hA, 4'h0, C_AL);
    drain("after_abort");
    check_v("abort_memwr_pulses", 16'(memwr3_cnt - m0), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
